// File: rtl/updown_wrap_monitor.sv
// updown_wrap_monitor
// Watches a free-running 3-bit up/down counter and checks every step it takes.
// Legal wraps (7->0 counting up, 0->7 counting down) are counted, and each one
// produces a one-cycle terminal-count pulse. An illegal step sets a sticky
// error and freezes the counts until clr or rst.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   asynchronous active-low reset
//   m         in   counter direction (1 = up, 0 = down)
//   q[2:0]    in   monitored counter value
//   clr       in   synchronous clear of counts/error, active-high
//   tc        out  one-cycle pulse after a legal wrap is sampled
//   wrap_up   out  saturating count of legal 7->0 wraps
//   wrap_dn   out  saturating count of legal 0->7 wraps
//   step_err  out  sticky illegal-step flag
//   tracking  out  high while steps are being checked
module updown_wrap_monitor (
  input  logic       clk,
  input  logic       rst,
  input  logic       m,
  input  logic [2:0] q,
  input  logic       clr,
  output logic       tc,
  output logic [7:0] wrap_up,
  output logic [7:0] wrap_dn,
  output logic       step_err,
  output logic       tracking
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    ERR   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [2:0] prev_q;
  logic       prev_m;
  logic       tc_nx;
  logic [7:0] wrap_up_nx;
  logic [7:0] wrap_dn_nx;
  logic       err_nx;
  logic [2:0] q_inc;
  logic [2:0] q_dec;

  // 3-bit arithmetic gives the mod-8 neighbours of the previous value for free.
  assign q_inc    = prev_q + 3'd1;
  assign q_dec    = prev_q - 3'd1;
  assign tracking = (state == TRACK);

  // prev_q/prev_m are captured unconditionally so that the step checked on the
  // next edge is always judged against the direction that produced it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= INIT;
      prev_q   <= 3'd0;
      prev_m   <= 1'b0;
      tc       <= 1'b0;
      wrap_up  <= 8'd0;
      wrap_dn  <= 8'd0;
      step_err <= 1'b0;
    end else begin
      state    <= state_nx;
      prev_q   <= q;
      prev_m   <= m;
      tc       <= tc_nx;
      wrap_up  <= wrap_up_nx;
      wrap_dn  <= wrap_dn_nx;
      step_err <= err_nx;
    end
  end

  // Next-state and next-output logic. clr overrides any wrap or error seen on
  // the same edge. A hold (q unchanged) is legal in either direction.
  always_comb begin
    state_nx   = state;
    tc_nx      = 1'b0;
    wrap_up_nx = wrap_up;
    wrap_dn_nx = wrap_dn;
    err_nx     = step_err;

    if (clr) begin
      state_nx   = INIT;
      wrap_up_nx = 8'd0;
      wrap_dn_nx = 8'd0;
      err_nx     = 1'b0;
    end else begin
      case (state)
        INIT: begin
          state_nx = TRACK;
        end

        TRACK: begin
          if (q == prev_q) begin
            state_nx = TRACK;
          end else if (prev_m && (q == q_inc)) begin
            if (prev_q == 3'd7) begin
              tc_nx      = 1'b1;
              wrap_up_nx = (wrap_up == 8'd255) ? wrap_up : wrap_up + 8'd1;
            end
          end else if (!prev_m && (q == q_dec)) begin
            if (prev_q == 3'd0) begin
              tc_nx      = 1'b1;
              wrap_dn_nx = (wrap_dn == 8'd255) ? wrap_dn : wrap_dn + 8'd1;
            end
          end else begin
            err_nx   = 1'b1;
            state_nx = ERR;
          end
        end

        ERR: begin
          state_nx = ERR;
          err_nx   = 1'b1;
        end

        default: begin
          state_nx = INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_updown_wrap_monitor.sv
// Directed testbench for updown_wrap_monitor. Inputs change 1 time unit after
// each rising edge; outputs are sampled at that same point, so each sample
// reflects the edge that consumed the previous set of inputs.
module tb_updown_wrap_monitor;

  logic       clk;
  logic       rst;
  logic       m;
  logic [2:0] q;
  logic       clr;
  logic       tc;
  logic [7:0] wrap_up;
  logic [7:0] wrap_dn;
  logic       step_err;
  logic       tracking;

  int checks;
  int errors;
  int tc_pulses;

  updown_wrap_monitor dut (
    .clk      (clk),
    .rst      (rst),
    .m        (m),
    .q        (q),
    .clr      (clr),
    .tc       (tc),
    .wrap_up  (wrap_up),
    .wrap_dn  (wrap_dn),
    .step_err (step_err),
    .tracking (tracking)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drives one input vector, lets one rising edge consume it, then returns
  // just after that edge.
  task automatic applyStimulus(input logic nm, input logic [2:0] nq,
                               input logic nclr);
    m   = nm;
    q   = nq;
    clr = nclr;
    @(posedge clk);
    #1;
  endtask

  // Checks all outputs against zero; used right after an asynchronous reset.
  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_tc"},       {7'd0, tc},       8'd0);
    checkOutput({tag, "_wrap_up"},  wrap_up,          8'd0);
    checkOutput({tag, "_wrap_dn"},  wrap_dn,          8'd0);
    checkOutput({tag, "_step_err"}, {7'd0, step_err}, 8'd0);
    checkOutput({tag, "_tracking"}, {7'd0, tracking}, 8'd0);
  endtask

  // Asserts reset between edges, checks outputs cleared before any edge,
  // holds it across one edge and releases it between edges.
  task automatic pulseReset(input string tag);
    rst = 1'b0;
    #2;
    checkAllZero(tag);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    tc_pulses = 0;
    rst = 1'b0;
    m   = 1'b0;
    q   = 3'd0;
    clr = 1'b0;

    // Reset state.
    #2;
    checkAllZero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Counting up 0..7,0..7,0: two wraps, tc after each sampled 0.
    applyStimulus(1'b1, 3'd0, 1'b0);
    checkOutput("s1_track_after_init", {7'd0, tracking}, 8'd1);
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 3'(i % 8), 1'b0);
      checkOutput("s1_tc", {7'd0, tc}, (i == 8 || i == 16) ? 8'd1 : 8'd0);
      if (tc) tc_pulses++;
    end
    checkOutput("s1_tc_pulses", 8'(tc_pulses), 8'd2);
    checkOutput("s1_wrap_up", wrap_up, 8'd2);
    checkOutput("s1_wrap_dn", wrap_dn, 8'd0);
    checkOutput("s1_step_err", {7'd0, step_err}, 8'd0);
    applyStimulus(1'b1, 3'd0, 1'b0);
    checkOutput("s1_tc_one_cycle", {7'd0, tc}, 8'd0);

    // Counting down 7..0,7 after a fresh reset: one down wrap.
    pulseReset("s2_reset");
    applyStimulus(1'b0, 3'd7, 1'b0);
    for (int j = 1; j <= 8; j++) begin
      applyStimulus(1'b0, 3'(7 - j), 1'b0);
      checkOutput("s2_tc", {7'd0, tc}, (j == 8) ? 8'd1 : 8'd0);
    end
    checkOutput("s2_wrap_dn", wrap_dn, 8'd1);
    checkOutput("s2_wrap_up", wrap_up, 8'd0);
    applyStimulus(1'b0, 3'd7, 1'b0);
    checkOutput("s2_tc_drop", {7'd0, tc}, 8'd0);

    // Direction change: back up through 7->0, then down from 5, then a jump.
    applyStimulus(1'b1, 3'd7, 1'b0);
    applyStimulus(1'b1, 3'd0, 1'b0);
    checkOutput("s3_up_wrap_tc", {7'd0, tc}, 8'd1);
    checkOutput("s3_wrap_up", wrap_up, 8'd1);
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 3'(i), 1'b0);
    applyStimulus(1'b0, 3'd5, 1'b0);
    applyStimulus(1'b0, 3'd4, 1'b0);
    applyStimulus(1'b0, 3'd3, 1'b0);
    checkOutput("s3_no_err", {7'd0, step_err}, 8'd0);
    checkOutput("s3_still_tracking", {7'd0, tracking}, 8'd1);
    applyStimulus(1'b0, 3'd6, 1'b0);
    checkOutput("s3_err", {7'd0, step_err}, 8'd1);
    checkOutput("s3_err_tracking", {7'd0, tracking}, 8'd0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 3'(i % 8), 1'b0);
      checkOutput("s3_err_tc", {7'd0, tc}, 8'd0);
    end
    checkOutput("s3_frozen_up", wrap_up, 8'd1);
    checkOutput("s3_frozen_dn", wrap_dn, 8'd1);
    checkOutput("s3_err_sticky", {7'd0, step_err}, 8'd1);

    // clr leaves ERR; the INIT capture edge then restores tracking.
    applyStimulus(1'b1, 3'd0, 1'b1);
    checkOutput("s4_clr_err", {7'd0, step_err}, 8'd0);
    checkOutput("s4_clr_up", wrap_up, 8'd0);
    checkOutput("s4_clr_dn", wrap_dn, 8'd0);
    checkOutput("s4_clr_tracking", {7'd0, tracking}, 8'd0);
    applyStimulus(1'b1, 3'd0, 1'b0);
    checkOutput("s4_tracking", {7'd0, tracking}, 8'd1);

    // 257 up wraps: count saturates at 255 while tc keeps pulsing.
    for (int w = 1; w <= 257; w++) begin
      for (int i = 1; i <= 7; i++) applyStimulus(1'b1, 3'(i), 1'b0);
      applyStimulus(1'b1, 3'd0, 1'b0);
      checkOutput("s5_tc", {7'd0, tc}, 8'd1);
      if (w == 254) checkOutput("s5_wrap_up_254", wrap_up, 8'd254);
      if (w == 255) checkOutput("s5_wrap_up_255", wrap_up, 8'd255);
    end
    checkOutput("s5_wrap_up_sat", wrap_up, 8'd255);
    checkOutput("s5_step_err", {7'd0, step_err}, 8'd0);

    // clr on the same edge as a 7->0 wrap wins over the wrap.
    for (int i = 1; i <= 7; i++) applyStimulus(1'b1, 3'(i), 1'b0);
    applyStimulus(1'b1, 3'd0, 1'b1);
    checkOutput("s6_clr_wrap_up", wrap_up, 8'd0);
    checkOutput("s6_clr_tc", {7'd0, tc}, 8'd0);
    checkOutput("s6_clr_tracking", {7'd0, tracking}, 8'd0);
    applyStimulus(1'b1, 3'd1, 1'b0);
    checkOutput("s6_tracking", {7'd0, tracking}, 8'd1);
    applyStimulus(1'b1, 3'd2, 1'b0);
    checkOutput("s6_step_err", {7'd0, step_err}, 8'd0);

    // Asynchronous reset right after a wrap clears everything before an edge.
    for (int i = 3; i <= 7; i++) applyStimulus(1'b1, 3'(i), 1'b0);
    applyStimulus(1'b1, 3'd0, 1'b0);
    checkOutput("s7_pre_tc", {7'd0, tc}, 8'd1);
    checkOutput("s7_pre_wrap_up", wrap_up, 8'd1);
    pulseReset("s7_async");
    applyStimulus(1'b1, 3'd5, 1'b0);
    checkOutput("s7_init_tracking", {7'd0, tracking}, 8'd1);
    checkOutput("s7_init_no_err", {7'd0, step_err}, 8'd0);
    applyStimulus(1'b1, 3'd6, 1'b0);
    checkOutput("s7_step_ok", {7'd0, step_err}, 8'd0);
    checkOutput("s7_wrap_up", wrap_up, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
